// File: rtl/hazard_stall_ctrl.sv
// Hazard / stall controller for a five-stage pipeline.
// Detects register read-after-write hazards between the D stage and the
// E/M stages (Tuse/Tnew scheme), tracks the multi-cycle mult/div unit and
// freezes the front end while either kind of hazard is present. A
// saturating counter records how many cycles were lost to stalls.
module hazard_stall_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_rs_addr,
    input  logic [4:0]       D_rt_addr,
    input  logic [1:0]       D_tuse_rs,
    input  logic [1:0]       D_tuse_rt,
    input  logic [4:0]       E_wa,
    input  logic [1:0]       E_tnew,
    input  logic [4:0]       M_wa,
    input  logic [1:0]       M_tnew,
    input  logic             D_md_use,
    input  logic             E_md_start,
    input  logic             E_md_type,
    output logic             stall,
    output logic             E_clr,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t        state_q, state_d;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Source operand 0 is rs, operand 1 is rt; both use the same check.
    logic [4:0] src_addr [2];
    logic [1:0] src_tuse [2];
    logic [1:0] src_hazard;
    logic       md_hazard;

    assign src_addr[0] = D_rs_addr;
    assign src_addr[1] = D_rt_addr;
    assign src_tuse[0] = D_tuse_rs;
    assign src_tuse[1] = D_tuse_rt;

    // A producer is a hazard only if its result arrives later than the
    // consumer needs it. $zero is never a real dependency, and a tuse of 3
    // can never be exceeded by a 2-bit tnew, so "unused" falls out naturally.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            always_comb begin
                src_hazard[gi] = (src_addr[gi] != 5'd0) &&
                                 (((E_wa == src_addr[gi]) && (E_tnew > src_tuse[gi])) ||
                                  ((M_wa == src_addr[gi]) && (M_tnew > src_tuse[gi])));
            end
        end
    endgenerate

    // The start cycle itself counts as busy, so a dependent instruction in D
    // is held even before the FSM has registered the start.
    assign md_busy   = E_md_start || (state_q == BUSY);
    assign md_hazard = D_md_use && md_busy;
    assign stall     = src_hazard[0] || src_hazard[1] || md_hazard;
    assign E_clr     = stall;
    assign stall_cnt = stall_cnt_q;

    // Mult/div occupancy FSM next state; starts while busy are ignored.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            IDLE: begin
                if (E_md_start) begin
                    state_d  = BUSY;
                    md_cnt_d = E_md_type ? 4'(DIV_LAT) : 4'(MULT_LAT);
                end
            end
            BUSY: begin
                if (md_cnt_q <= 4'd1) begin
                    state_d  = IDLE;
                    md_cnt_d = 4'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = 4'd0;
            end
        endcase
    end

    // Stall counter next state: count each stalled edge, stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset aborts any mult/div window and clears the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl. A second instance with a 4-bit
// stall counter shares all inputs and is used for the saturation scenario.
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_md_use, E_md_start, E_md_type;
    logic        stall, E_clr, md_busy;
    logic [15:0] stall_cnt;
    logic        s_stall, s_E_clr, s_md_busy;
    logic [3:0]  s_stall_cnt;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_sat;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .D_md_use(D_md_use), .E_md_start(E_md_start), .E_md_type(E_md_type),
        .stall(stall), .E_clr(E_clr), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    hazard_stall_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .D_md_use(D_md_use), .E_md_start(E_md_start), .E_md_type(E_md_type),
        .stall(s_stall), .E_clr(s_E_clr), .md_busy(s_md_busy), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        D_rs_addr  = 5'd0;
        D_rt_addr  = 5'd0;
        D_tuse_rs  = 2'd3;
        D_tuse_rt  = 2'd3;
        E_wa       = 5'd0;
        E_tnew     = 2'd0;
        M_wa       = 5'd0;
        M_tnew     = 2'd0;
        D_md_use   = 1'b0;
        E_md_start = 1'b0;
        E_md_type  = 1'b0;
    endtask

    // Advance to just after the next rising edge (start of a new cycle).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (stall !== 1'b0 || E_clr !== 1'b0 || md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: stall=%b E_clr=%b md_busy=%b, expected 0 0 0", stall, E_clr, md_busy);
        end
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: stall_cnt=%0d, expected 0", stall_cnt);
        end
        E_md_start = 1'b1;
        #1;
        n_checks++;
        if (md_busy !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_md_follow: md_busy=%b stall=%b, expected 1 0", md_busy, stall);
        end
        D_md_use = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1 || E_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall_comb: stall=%b E_clr=%b, expected 1 1", stall, E_clr);
        end
        // Edges while held in reset must not start the FSM or count.
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_hold_cnt: stall_cnt=%0d, expected 0", stall_cnt);
        end
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: md_busy=%b, expected 0", md_busy);
        end
        exp_cnt = 16'd0;
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        next_cycle();
        D_rs_addr = 5'd8; D_tuse_rs = 2'd0; E_wa = 5'd8; E_tnew = 2'd2;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || E_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall: stall=%b E_clr=%b, expected 1 1", stall, E_clr);
        end
        next_cycle();
        exp_cnt = exp_cnt + 16'd1;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (stall_cnt !== exp_cnt || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_cnt: stall_cnt=%0d stall=%b, expected %0d 0", stall_cnt, stall, exp_cnt);
        end
        // rt against the M stage: tnew 2 > tuse 1 stalls, tnew 1 does not.
        next_cycle();
        D_rt_addr = 5'd7; D_tuse_rt = 2'd1; M_wa = 5'd7; M_tnew = 2'd2;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rt_m_hazard: stall=%b, expected 1", stall);
        end
        #1 M_tnew = 2'd1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rt_m_ready: stall=%b, expected 0", stall);
        end
        next_cycle();
        clear_inputs();
        $display("test_load_use done, expected stall_cnt=%0d", exp_cnt);
    endtask

    task automatic test_no_hazard();
        next_cycle();
        D_rs_addr = 5'd0; E_wa = 5'd0; E_tnew = 2'd2; D_tuse_rs = 2'd0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg: stall=%b, expected 0", stall);
        end
        #1 D_rs_addr = 5'd5; E_wa = 5'd5; D_tuse_rs = 2'd3;
        #1;
        n_checks++;
        if (stall !== 1'b0 || E_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL tuse3: stall=%b E_clr=%b, expected 0 0", stall, E_clr);
        end
        D_tuse_rs = 2'd2;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL tnew_eq_tuse: stall=%b, expected 0", stall);
        end
        D_tuse_rs = 2'd3;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (stall_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL no_hazard_cnt: stall_cnt=%0d, expected %0d", stall_cnt, exp_cnt);
        end
        $display("test_no_hazard done");
    endtask

    task automatic test_multi_hazard();
        next_cycle();
        D_rs_addr = 5'd8; D_tuse_rs = 2'd0; E_wa = 5'd8; E_tnew = 2'd1;
        D_rt_addr = 5'd9; D_tuse_rt = 2'd0; M_wa = 5'd9; M_tnew = 2'd1;
        D_md_use = 1'b1; E_md_start = 1'b1; E_md_type = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_stall: stall=%b, expected 1", stall);
        end
        next_cycle();
        exp_cnt = exp_cnt + 16'd1;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (stall_cnt !== exp_cnt || md_busy !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_cnt: stall_cnt=%0d md_busy=%b stall=%b, expected %0d 1 0",
                     stall_cnt, md_busy, stall, exp_cnt);
        end
        for (int i = 0; i < 5; i++) next_cycle();
        @(negedge clk);
        n_checks++;
        if (md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_idle: md_busy=%b, expected 0", md_busy);
        end
        $display("test_multi_hazard done, expected stall_cnt=%0d", exp_cnt);
    endtask

    task automatic test_mult();
        logic exp_b;
        for (int c = 0; c <= 6; c++) begin
            next_cycle();
            D_md_use   = 1'b1;
            E_md_type  = 1'b0;
            E_md_start = (c == 0);
            @(negedge clk);
            exp_b = (c <= 5);
            n_checks++;
            if (md_busy !== exp_b || stall !== exp_b || stall_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL mult_c%0d: md_busy=%b stall=%b cnt=%0d, expected %b %b %0d",
                         c, md_busy, stall, stall_cnt, exp_b, exp_b, exp_cnt);
            end
            if (exp_b) exp_cnt = exp_cnt + 16'd1;
        end
        next_cycle();
        clear_inputs();
        $display("test_mult done");
    endtask

    task automatic test_div();
        logic exp_b;
        for (int c = 0; c <= 11; c++) begin
            next_cycle();
            D_md_use   = 1'b1;
            E_md_type  = 1'b1;
            E_md_start = (c == 0 || c == 4);
            @(negedge clk);
            exp_b = (c <= 10);
            n_checks++;
            if (md_busy !== exp_b || stall !== exp_b || stall_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL div_c%0d: md_busy=%b stall=%b cnt=%0d, expected %b %b %0d",
                         c, md_busy, stall, stall_cnt, exp_b, exp_b, exp_cnt);
            end
            if (exp_b) exp_cnt = exp_cnt + 16'd1;
        end
        next_cycle();
        clear_inputs();
        $display("test_div done");
    endtask

    task automatic test_back_to_back();
        logic exp_b;
        for (int c = 0; c <= 12; c++) begin
            next_cycle();
            D_md_use   = 1'b0;
            E_md_type  = 1'b0;
            E_md_start = (c == 0 || c == 6);
            @(negedge clk);
            exp_b = (c <= 11);
            n_checks++;
            if (md_busy !== exp_b || stall !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_c%0d: md_busy=%b stall=%b, expected %b 0", c, md_busy, stall, exp_b);
            end
        end
        next_cycle();
        clear_inputs();
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_div();
        for (int c = 0; c <= 2; c++) begin
            next_cycle();
            D_md_use   = 1'b1;
            E_md_type  = 1'b1;
            E_md_start = (c == 0);
        end
        next_cycle();
        E_md_start = 1'b0;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (md_busy !== 1'b0 || stall !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_div_reset: md_busy=%b stall=%b cnt=%0d, expected 0 0 0", md_busy, stall, stall_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 16'd0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            D_md_use   = 1'b1;
            E_md_start = 1'b0;
            @(negedge clk);
            n_checks++;
            if (stall !== 1'b0 || md_busy !== 1'b0 || stall_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL post_reset_c%0d: stall=%b md_busy=%b cnt=%0d, expected 0 0 %0d",
                         c, stall, md_busy, stall_cnt, exp_cnt);
            end
        end
        next_cycle();
        clear_inputs();
        $display("test_reset_mid_div done");
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            D_rs_addr = 5'd3; D_tuse_rs = 2'd0; E_wa = 5'd3; E_tnew = 2'd2;
            @(negedge clk);
            exp_sat = (c >= 15) ? 4'd15 : 4'(c);
            n_checks++;
            if (s_stall_cnt !== exp_sat || s_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_c%0d: stall_cnt=%0d stall=%b, expected %0d 1", c, s_stall_cnt, s_stall, exp_sat);
            end
        end
        next_cycle();
        clear_inputs();
        exp_cnt = exp_cnt + 16'd20;
        @(negedge clk);
        n_checks++;
        if (s_stall_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_hold: stall_cnt=%0d, expected 15", s_stall_cnt);
        end
        n_checks++;
        if (stall_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL wide_cnt: stall_cnt=%0d, expected %0d", stall_cnt, exp_cnt);
        end
        $display("test_saturation done");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 16'd0;
        exp_sat  = 4'd0;
        reset    = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_multi_hazard();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_mid_div();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameters SHALL be: MULT_LAT, default 5, mult busy cycles after start; DIV_LAT, default 10, div busy cycles after start; CNT_W, default 16, stall-counter width.
REQ-002 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- D_rs_addr  in  5  D-stage rs index
- D_rt_addr  in  5  D-stage rt index
- D_tuse_rs  in  2  cycles until D needs rs (3 = unused)
- D_tuse_rt  in  2  cycles until D needs rt (3 = unused)
- E_wa  in  5  E-stage write register
- E_tnew  in  2  cycles until E result ready
- M_wa  in  5  M-stage write register
- M_tnew  in  2  cycles until M result ready
- D_md_use  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
- E_md_start  in  1  E instr starts mult/div this cycle
- E_md_type  in  1  0 = mult, 1 = div
- stall  out  1  freeze PC and F/D register
- E_clr  out  1  insert bubble into D/E register
- md_busy  out  1  mult/div unit occupied
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Function
REQ-003 The block SHALL compute rs_hazard = (D_rs_addr != 0) and ((E_wa == D_rs_addr and E_tnew > D_tuse_rs) or (M_wa == D_rs_addr and M_tnew > D_tuse_rs)).
REQ-004 rt_hazard SHALL be computed identically, using D_rt_addr and D_tuse_rt.
REQ-005 Register 0 SHALL never cause a hazard.
REQ-006 A tuse of 3 SHALL never cause a hazard.
REQ-007 The mult/div FSM SHALL have two states, IDLE and BUSY, plus a 4-bit down-counter md_cnt.
REQ-008 IDLE with E_md_start = 1 SHALL go to BUSY, loading md_cnt with MULT_LAT when E_md_type = 0 and DIV_LAT when E_md_type = 1.
REQ-009 In BUSY, md_cnt SHALL decrement each cycle; when md_cnt = 1 the FSM SHALL return to IDLE at the next edge with md_cnt = 0.
REQ-010 A busy window SHALL therefore occupy exactly LAT cycles following the start cycle.
REQ-011 E_md_start asserted in BUSY SHALL be ignored: no reload, no state change.
REQ-012 md_busy SHALL be combinational: E_md_start or (state == BUSY).
REQ-013 md_hazard SHALL be D_md_use and md_busy.
REQ-014 stall SHALL be combinational: rs_hazard or rt_hazard or md_hazard, with zero-cycle latency from the inputs.
REQ-015 E_clr SHALL equal stall in every cycle.
REQ-016 stall_cnt SHALL increment by 1 on each rising edge where stall = 1.
REQ-017 stall_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-018 When several hazards occur in the same cycle, stall SHALL be asserted once and stall_cnt SHALL increment by exactly 1.
REQ-019 The block SHALL contain no PC-select logic; it only gates the PC update through stall.

Reset
REQ-020 reset = 0 SHALL immediately, without waiting for a clock edge, force state = IDLE, md_cnt = 0 and stall_cnt = 0.
REQ-021 During and after reset, md_busy SHALL follow E_md_start only, and stall/E_clr SHALL follow the combinational hazard terms.
REQ-022 Reset asserted mid-BUSY SHALL abort the busy window; after release, D_md_use = 1 SHALL NOT stall unless E_md_start = 1.
REQ-023 Reset release SHALL take effect on the first rising clk edge where reset = 1.

Verification
REQ-024 Load-use: D_rs_addr = 8, D_tuse_rs = 0, E_wa = 8, E_tnew = 2 -> stall = 1 and E_clr = 1; after that edge, stall_cnt = 1.
REQ-025 No-hazard: D_rs_addr = 0, E_wa = 0, E_tnew = 2 -> stall = 0; D_tuse_rs = 3, E_wa = D_rs_addr = 5, E_tnew = 2 -> stall = 0.
REQ-026 Mult: E_md_start = 1, E_md_type = 0 at cycle 0, D_md_use = 1 held -> md_busy = 1 and stall = 1 in cycles 0..5, both = 0 in cycle 6.
REQ-027 Div: same stimulus with E_md_type = 1 -> md_busy = 1 in cycles 0..10, md_busy = 0 in cycle 11; a second E_md_start in cycle 4 does not extend the window.
REQ-028 Reset mid-div: reset = 0 in cycle 3 -> md_busy = 0 and stall_cnt = 0 immediately; after release, D_md_use = 1 with E_md_start = 0 -> stall = 0.
REQ-029 Saturation: CNT_W = 4, stall held high for 20 cycles -> stall_cnt = 15 and holds at 15.
